// File: rtl/user_ram_pipe.sv
// Single-port word RAM with byte enables, RD_LAT-deep read pipeline and a sequential clear engine.
// Optional per-byte even parity storage and par_err_o when USER_RAM_PARITY_EN is defined.
module user_ram_pipe #(
    parameter int          ADDR_BIT  = 8,
    parameter int          DEPTH     = 2**ADDR_BIT,
    parameter int          DATA_W    = 32,
    parameter int          RD_LAT    = 1,
    parameter logic [31:0] IDLE_WORD = 32'h16110400
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                wr_en_i,
    input  logic                rd_en_i,
    input  logic [DATA_W/8-1:0] be_i,
    input  logic [ADDR_BIT-1:0] addr_i,
    input  logic [DATA_W-1:0]   di_i,
    input  logic                clr_i,
    output logic                ready_o,
    output logic                busy_o,
    output logic                rd_valid_o,
    output logic [DATA_W-1:0]   do_o,
`ifdef USER_RAM_PARITY_EN
    output logic                addr_err_o,
    output logic                par_err_o
`else
    output logic                addr_err_o
`endif
);
    localparam int                NB       = DATA_W / 8;
    localparam logic [DATA_W-1:0] IDLE_VAL = DATA_W'(IDLE_WORD);

    typedef enum logic {CLEAR, IDLE} state_t;

    state_t              state, state_nxt;
    logic [ADDR_BIT-1:0] cnt;
    logic                accept, in_range, rd_acc, wr_acc, clr_we, last;
    logic [RD_LAT:1]     vld_pipe;
    logic [DATA_W-1:0]   dat_pipe [1:RD_LAT];
    logic [DATA_W-1:0]   mem      [DEPTH];

    assign busy_o   = (state == CLEAR);
    assign ready_o  = ~busy_o;
    assign accept   = (state == IDLE);
    assign in_range = {1'b0, addr_i} < (ADDR_BIT+1)'(DEPTH);
    assign rd_acc   = accept & rd_en_i;
    assign wr_acc   = accept & wr_en_i & in_range;
    assign last     = (cnt == ADDR_BIT'(DEPTH - 1));
    // No array writes while reset is held; the clear starts on release.
    assign clr_we   = busy_o & rst_i;

    always_comb begin
        state_nxt = state;
        case (state)
            CLEAR:   if (last)  state_nxt = IDLE;
            IDLE:    if (clr_i) state_nxt = CLEAR;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= CLEAR;
            cnt        <= '0;
            addr_err_o <= 1'b0;
            vld_pipe   <= '0;
        end else begin
            state      <= state_nxt;
            cnt        <= (busy_o && !last) ? cnt + ADDR_BIT'(1) : '0;
            addr_err_o <= accept & (wr_en_i | rd_en_i) & ~in_range;
            vld_pipe[1] <= rd_acc;
            for (int k = 2; k <= RD_LAT; k++) vld_pipe[k] <= vld_pipe[k-1];
        end
    end

    // Array write and read sample share one edge: reads see the pre-write word.
    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            mem[cnt] <= '0;
        end else if (wr_acc) begin
            for (int b = 0; b < NB; b++)
                if (be_i[b]) mem[addr_i][8*b +: 8] <= di_i[8*b +: 8];
        end
        if (rd_acc) dat_pipe[1] <= in_range ? mem[addr_i] : '0;
        for (int k = 2; k <= RD_LAT; k++) dat_pipe[k] <= dat_pipe[k-1];
    end

    assign rd_valid_o = vld_pipe[RD_LAT];
    assign do_o       = vld_pipe[RD_LAT] ? dat_pipe[RD_LAT] : IDLE_VAL;

`ifdef USER_RAM_PARITY_EN
    logic [NB-1:0] par      [DEPTH];
    logic [RD_LAT:1] perr_pipe;

    function automatic logic [NB-1:0] byte_par(input logic [DATA_W-1:0] w);
        logic [NB-1:0] p;
        for (int b = 0; b < NB; b++) p[b] = ^w[8*b +: 8];
        return p;
    endfunction

    always_ff @(posedge clk_i) begin
        if (clr_we) begin
            par[cnt] <= '0;
        end else if (wr_acc) begin
            for (int b = 0; b < NB; b++)
                if (be_i[b]) par[addr_i][b] <= ^di_i[8*b +: 8];
        end
        if (rd_acc) perr_pipe[1] <= in_range & (|(byte_par(mem[addr_i]) ^ par[addr_i]));
        for (int k = 2; k <= RD_LAT; k++) perr_pipe[k] <= perr_pipe[k-1];
    end

    assign par_err_o = vld_pipe[RD_LAT] & perr_pipe[RD_LAT];
`endif
endmodule

// File: doc/user_ram_pipe.md
Name: user_ram_pipe

Overview:
- Parametrised single-port word RAM for the user peripheral space.
- Adds configurable data width and depth, per-byte write enables, and a programmable read-latency pipeline with a valid strobe.
- Adds a sequential hardware clear engine, which replaces a one-cycle whole-array reset, plus an out-of-range address flag.
- Sits behind the bus-to-peripheral adapter; the adapter stalls on ready_o and samples data on rd_valid_o.

Parameters:
- ADDR_BIT, 8, address width in words.
- DEPTH, 2**ADDR_BIT, number of implemented words; must be <= 2**ADDR_BIT.
- DATA_W, 32, word width; must be a multiple of 8.
- RD_LAT, 1, read latency in cycles from accepted request to rd_valid_o; legal range 1..4.
- IDLE_WORD, 32'h16110400, value driven on do_o whenever rd_valid_o=0; truncated or zero-extended to DATA_W.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- wr_en_i  in  1  write request.
- rd_en_i  in  1  read request.
- be_i  in  DATA_W/8  byte enables for writes; bit k selects di_i[8k+7:8k].
- addr_i  in  ADDR_BIT  word address.
- di_i  in  DATA_W  write data.
- clr_i  in  1  single-cycle pulse that starts a full clear.
- ready_o  out  1  requests are accepted this cycle (equals ~busy_o).
- busy_o  out  1  clear engine active.
- rd_valid_o  out  1  do_o carries read data this cycle.
- do_o  out  DATA_W  read data, or IDLE_WORD when rd_valid_o=0.
- addr_err_o  out  1  one-cycle pulse: an accepted request had addr_i >= DEPTH.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - Outputs: rd_valid_o=0, do_o=IDLE_WORD, addr_err_o=0, busy_o=1, ready_o=0.
  - Read pipeline flushed; clear counter=0; FSM=CLEAR.
  - Array contents are not reset directly.
- FSM states:
  - CLEAR: writes all-zero to word cnt each cycle, cnt increments.
    - Transitions to IDLE on the cycle after the write of DEPTH-1, giving exactly DEPTH cycles of busy_o=1 after rst_i rises.
    - clr_i is ignored; the clear is not restarted.
    - wr_en_i/rd_en_i are ignored and not queued.
  - IDLE: services requests.
    - clr_i=1 -> next cycle CLEAR with cnt=0.
    - A request in the same cycle as clr_i is still accepted.
- Write (IDLE, wr_en_i=1, addr_i<DEPTH): bytes with be_i[k]=1 are updated at the clock edge; other bytes are unchanged. be_i=0 is a legal no-op.
- Read (IDLE, rd_en_i=1, addr_i<DEPTH):
  - Array is sampled at the accept edge.
  - Result appears on do_o with rd_valid_o=1 for exactly one cycle, RD_LAT cycles later.
  - Back-to-back reads are fully pipelined: one result per cycle, in order.
- Simultaneous wr_en_i and rd_en_i at the same address: read-first; the read returns the old word and the write commits.
- Out of range (addr_i>=DEPTH):
  - Write is dropped.
  - Read returns 0 with rd_valid_o=1 at normal latency.
  - addr_err_o=1 on the cycle after accept.
- In-flight reads when CLEAR starts complete normally with pre-clear data.
- Reset mid-clear or mid-read: everything aborts, in-flight reads are lost (no rd_valid_o), and the clear restarts from 0 after release.

Optional Feature:
- USER_RAM_PARITY_EN defined:
  - One even-parity bit is stored per byte, updated with its byte on writes; the clear engine writes parity 0.
  - Extra output par_err_o (1 bit) is asserted alongside rd_valid_o when any byte of the returned word fails parity.
  - par_err_o is 0 for out-of-range reads and at reset.
- Undefined: no parity storage and no par_err_o port.

Test Plan:
- Release rst_i, DEPTH=256 -> busy_o=1 for exactly 256 cycles; then read of addr 0x00 and 0xFF returns 0 at RD_LAT; do_o=0x16110400 on all non-valid cycles.
- Write 0xAABBCCDD to addr 5 with be_i=4'b1111, then be_i=4'b0101 with data 0x11223344 -> read returns 0xAA22CC44.
- RD_LAT=3, reads of addr 1,2,3 on consecutive cycles -> rd_valid_o high for 3 consecutive cycles starting 3 cycles after the first, with data in order.
- Same-cycle write 0x55 and read at addr 7 (old 0x12) -> read returns 0x12; a following read returns 0x55.
- DEPTH=200, read addr 210 -> do_o=0 with rd_valid_o, addr_err_o pulse; write to 210 leaves addr 210-256 aliases untouched.
- clr_i pulse in IDLE, then rst_i asserted at clear cycle 10 -> outputs return to reset values immediately; full DEPTH-cycle clear after release; wr_en_i during busy_o has no effect.
